// File: rtl/integer_issue_queue.sv
// integer_issue_queue
//   Collapsing issue queue for integer (R/I/U/B/J) instructions. Holds
//   dispatched instructions until both source operands are available. Operands
//   are captured from the execute writeback broadcast. Each cycle the oldest
//   ready entry moves into a registered issue bundle for integer_execute.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   flush                  squash every entry and the issue register next edge
//   dispatch_*             instruction offered by dispatch (valid/ready handshake)
//   bcast_*                execute writeback broadcast (rob id + data)
//   issue_*                registered issue bundle; qualify fields on issue_valid
//
// iq_wakeup is the per-entry operand capture. It compares one entry's two
// source tags against the broadcast and returns the updated ready bits and
// data for that entry.

module iq_wakeup #(
  parameter int ROB_ID_W = 5,
  parameter int XLEN     = 32
) (
  input  logic [1:0]                src_ready,
  input  logic [1:0][ROB_ID_W-1:0]  src_tag,
  input  logic [1:0][XLEN-1:0]      src_data,
  input  logic                      bcast_valid,
  input  logic [ROB_ID_W-1:0]       bcast_rob_id,
  input  logic [XLEN-1:0]           bcast_data,
  output logic [1:0]                src_ready_nxt,
  output logic [1:0][XLEN-1:0]      src_data_nxt
);
  for (genvar s = 0; s < 2; s++) begin : g_src
    logic hit;
    assign hit              = bcast_valid && !src_ready[s] && (src_tag[s] == bcast_rob_id);
    assign src_ready_nxt[s] = src_ready[s] | hit;
    assign src_data_nxt[s]  = hit ? bcast_data : src_data[s];
  end
endmodule

module integer_issue_queue #(
  parameter int N_ENTRIES = 8,
  parameter int ROB_ID_W  = 5,
  parameter int XLEN      = 32,
  parameter int IMM_W     = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 dispatch_valid,
  output logic                 dispatch_ready,
  input  logic                 dispatch_src1_ready,
  input  logic                 dispatch_src2_ready,
  input  logic [ROB_ID_W-1:0]  dispatch_src1_tag,
  input  logic [ROB_ID_W-1:0]  dispatch_src2_tag,
  input  logic [XLEN-1:0]      dispatch_src1,
  input  logic [XLEN-1:0]      dispatch_src2,
  input  logic [IMM_W-1:0]     dispatch_imm,
  input  logic [ADDR_W-1:0]    dispatch_pc,
  input  logic [2:0]           dispatch_funct3,
  input  logic [8:0]           dispatch_ctrl,
  input  logic [ROB_ID_W-1:0]  dispatch_rob_id,
  input  logic                 dispatch_br_dir_pred,
  input  logic                 bcast_valid,
  input  logic [ROB_ID_W-1:0]  bcast_rob_id,
  input  logic [XLEN-1:0]      bcast_data,
  output logic                 issue_valid,
  output logic [XLEN-1:0]      issue_src1,
  output logic [XLEN-1:0]      issue_src2,
  output logic [IMM_W-1:0]     issue_imm,
  output logic [ADDR_W-1:0]    issue_pc,
  output logic [2:0]           issue_funct3,
  output logic [8:0]           issue_ctrl,
  output logic [ROB_ID_W-1:0]  issue_rob_id,
  output logic                 issue_br_dir_pred
);
  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  // Index 0 of rdy/tag/data is src1 and index 1 is src2.
  typedef struct packed {
    logic [1:0]               rdy;
    logic [1:0][ROB_ID_W-1:0] tag;
    logic [1:0][XLEN-1:0]     data;
    logic [IMM_W-1:0]         imm;
    logic [ADDR_W-1:0]        pc;
    logic [2:0]               funct3;
    logic [8:0]               ctrl;
    logic [ROB_ID_W-1:0]      rob_id;
    logic                     br;
  } iq_entry_t;

  iq_entry_t ents [N_ENTRIES];
  logic [CNT_W-1:0] count;

  // Slots 0..N-1 are the stored entries. Slot N is the dispatching
  // instruction, so it sees the same-cycle broadcast as well.
  iq_entry_t cand [N_ENTRIES+1];
  iq_entry_t upd  [N_ENTRIES+1];
  iq_entry_t nxt  [N_ENTRIES];
  logic [N_ENTRIES:0][1:0]           w_rdy;
  logic [N_ENTRIES:0][1:0][XLEN-1:0] w_data;

  logic [N_ENTRIES-1:0] valid, eligible;
  logic [IDX_W-1:0]     sel;
  logic                 issue_fire, accept;
  logic [CNT_W-1:0]     wr_idx, count_nxt;

  assign dispatch_ready = (count != CNT_W'(N_ENTRIES));
  assign accept         = dispatch_valid && dispatch_ready;
  assign wr_idx         = count - CNT_W'(issue_fire);
  assign count_nxt      = count - CNT_W'(issue_fire) + CNT_W'(accept);

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) cand[i] = ents[i];
    cand[N_ENTRIES]        = '0;
    cand[N_ENTRIES].rdy    = {dispatch_src2_ready, dispatch_src1_ready};
    cand[N_ENTRIES].tag    = {dispatch_src2_tag, dispatch_src1_tag};
    cand[N_ENTRIES].data   = {dispatch_src2, dispatch_src1};
    cand[N_ENTRIES].imm    = dispatch_imm;
    cand[N_ENTRIES].pc     = dispatch_pc;
    cand[N_ENTRIES].funct3 = dispatch_funct3;
    cand[N_ENTRIES].ctrl   = dispatch_ctrl;
    cand[N_ENTRIES].rob_id = dispatch_rob_id;
    cand[N_ENTRIES].br     = dispatch_br_dir_pred;
  end

  for (genvar i = 0; i <= N_ENTRIES; i++) begin : g_wake
    iq_wakeup #(.ROB_ID_W(ROB_ID_W), .XLEN(XLEN)) u_wake (
      .src_ready     (cand[i].rdy),
      .src_tag       (cand[i].tag),
      .src_data      (cand[i].data),
      .bcast_valid   (bcast_valid),
      .bcast_rob_id  (bcast_rob_id),
      .bcast_data    (bcast_data),
      .src_ready_nxt (w_rdy[i]),
      .src_data_nxt  (w_data[i])
    );
  end

  always_comb begin
    for (int i = 0; i <= N_ENTRIES; i++) begin
      upd[i]      = cand[i];
      upd[i].rdy  = w_rdy[i];
      upd[i].data = w_data[i];
    end
  end

  // Select uses start-of-cycle ready bits only. A wakeup this cycle becomes
  // eligible next cycle. Scan downward so the lowest (oldest) index wins.
  always_comb begin
    issue_fire = 1'b0;
    sel        = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      valid[i]    = CNT_W'(i) < count;
      eligible[i] = valid[i] && (&ents[i].rdy);
    end
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        issue_fire = 1'b1;
        sel        = IDX_W'(i);
      end
    end
  end

  // Collapse: entries at or above the issued slot shift down by one. The
  // dispatch lands at the new tail. The top slot may pick up the dispatch
  // copy as shift filler, which is harmless because it is beyond count.
  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      nxt[i] = upd[i];
      if (issue_fire && (i >= int'(sel))) nxt[i] = upd[i+1];
      if (accept && (wr_idx == CNT_W'(i))) nxt[i] = upd[N_ENTRIES];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count             <= '0;
      issue_valid       <= 1'b0;
      issue_src1        <= '0;
      issue_src2        <= '0;
      issue_imm         <= '0;
      issue_pc          <= '0;
      issue_funct3      <= '0;
      issue_ctrl        <= '0;
      issue_rob_id      <= '0;
      issue_br_dir_pred <= 1'b0;
      for (int i = 0; i < N_ENTRIES; i++) ents[i] <= '0;
    end else if (flush) begin
      count       <= '0;
      issue_valid <= 1'b0;
    end else begin
      count       <= count_nxt;
      issue_valid <= issue_fire;
      for (int i = 0; i < N_ENTRIES; i++) ents[i] <= nxt[i];
      if (issue_fire) begin
        issue_src1        <= ents[sel].data[0];
        issue_src2        <= ents[sel].data[1];
        issue_imm         <= ents[sel].imm;
        issue_pc          <= ents[sel].pc;
        issue_funct3      <= ents[sel].funct3;
        issue_ctrl        <= ents[sel].ctrl;
        issue_rob_id      <= ents[sel].rob_id;
        issue_br_dir_pred <= ents[sel].br;
      end
    end
  end

  a_no_dispatch_when_full: assert property (@(posedge clk) disable iff (rst)
    !(dispatch_valid && !dispatch_ready));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_W'(N_ENTRIES));

endmodule

// File: tb/tb_integer_issue_queue.sv
module tb_integer_issue_queue;
  localparam int N = 8;

  logic clk = 1'b0, rst, flush;
  logic dispatch_valid, dispatch_ready, dispatch_src1_ready, dispatch_src2_ready;
  logic [4:0]  dispatch_src1_tag, dispatch_src2_tag, dispatch_rob_id;
  logic [31:0] dispatch_src1, dispatch_src2, dispatch_imm, dispatch_pc;
  logic [2:0]  dispatch_funct3;
  logic [8:0]  dispatch_ctrl;
  logic        dispatch_br_dir_pred;
  logic        bcast_valid;
  logic [4:0]  bcast_rob_id;
  logic [31:0] bcast_data;
  logic        issue_valid, issue_br_dir_pred;
  logic [31:0] issue_src1, issue_src2, issue_imm, issue_pc;
  logic [2:0]  issue_funct3;
  logic [8:0]  issue_ctrl;
  logic [4:0]  issue_rob_id;

  integer_issue_queue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_src1_ready(dispatch_src1_ready), .dispatch_src2_ready(dispatch_src2_ready),
    .dispatch_src1_tag(dispatch_src1_tag), .dispatch_src2_tag(dispatch_src2_tag),
    .dispatch_src1(dispatch_src1), .dispatch_src2(dispatch_src2),
    .dispatch_imm(dispatch_imm), .dispatch_pc(dispatch_pc),
    .dispatch_funct3(dispatch_funct3), .dispatch_ctrl(dispatch_ctrl),
    .dispatch_rob_id(dispatch_rob_id), .dispatch_br_dir_pred(dispatch_br_dir_pred),
    .bcast_valid(bcast_valid), .bcast_rob_id(bcast_rob_id), .bcast_data(bcast_data),
    .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_funct3(issue_funct3),
    .issue_ctrl(issue_ctrl), .issue_rob_id(issue_rob_id),
    .issue_br_dir_pred(issue_br_dir_pred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        s1r, s2r;
    logic [4:0]  s1t, s2t, rob;
    logic [31:0] s1, s2, imm, pc;
    logic [2:0]  f3;
    logic [8:0]  ctrl;
    logic        br;
  } instr_t;

  instr_t mq[$];   // program-ordered queue of waiting instructions
  instr_t exp_b;   // last issued bundle (fields hold between issues)
  logic   exp_iv;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t wake(input instr_t e);
    instr_t r = e;
    if (bcast_valid && !r.s1r && r.s1t == bcast_rob_id) begin r.s1r = 1; r.s1 = bcast_data; end
    if (bcast_valid && !r.s2r && r.s2t == bcast_rob_id) begin r.s2r = 1; r.s2 = bcast_data; end
    return r;
  endfunction

  function automatic instr_t zero_instr();
    instr_t z;
    z.s1r = 0; z.s2r = 0; z.s1t = 0; z.s2t = 0; z.rob = 0; z.s1 = 0; z.s2 = 0;
    z.imm = 0; z.pc = 0; z.f3 = 0; z.ctrl = 0; z.br = 0;
    return z;
  endfunction

  task automatic check_outputs();
    chk("issue_valid", issue_valid, exp_iv);
    chk("dispatch_ready", dispatch_ready, mq.size() != N);
    chk("issue_rob_id", issue_rob_id, exp_b.rob);
    chk("issue_src1", issue_src1, exp_b.s1);
    chk("issue_src2", issue_src2, exp_b.s2);
    chk("issue_imm", issue_imm, exp_b.imm);
    chk("issue_pc", issue_pc, exp_b.pc);
    chk("issue_funct3", issue_funct3, exp_b.f3);
    chk("issue_ctrl", issue_ctrl, exp_b.ctrl);
    chk("issue_br", issue_br_dir_pred, exp_b.br);
  endtask

  // One clock: the model consumes the currently driven inputs, then the DUT
  // is compared just after the edge.
  task automatic cycle();
    instr_t cur;
    int sel = -1;
    for (int i = 0; i < mq.size(); i++)
      if (sel < 0 && mq[i].s1r && mq[i].s2r) sel = i;
    if (flush) begin
      mq.delete();
      exp_iv = 0;
    end else begin
      exp_iv = (sel >= 0);
      if (sel >= 0) exp_b = mq[sel];
      foreach (mq[i]) mq[i] = wake(mq[i]);
      if (sel >= 0) mq.delete(sel);
      if (dispatch_valid && dispatch_ready) begin
        cur.s1r = dispatch_src1_ready; cur.s2r = dispatch_src2_ready;
        cur.s1t = dispatch_src1_tag;   cur.s2t = dispatch_src2_tag;
        cur.s1 = dispatch_src1; cur.s2 = dispatch_src2;
        cur.imm = dispatch_imm; cur.pc = dispatch_pc; cur.f3 = dispatch_funct3;
        cur.ctrl = dispatch_ctrl; cur.rob = dispatch_rob_id; cur.br = dispatch_br_dir_pred;
        mq.push_back(wake(cur));
      end
    end
    @(posedge clk); #1;
    check_outputs();
  endtask

  task automatic set_disp(input logic [4:0] rob, input logic r1, input logic [4:0] t1,
                          input logic [31:0] d1, input logic r2, input logic [4:0] t2,
                          input logic [31:0] d2);
    dispatch_valid = 1; dispatch_rob_id = rob;
    dispatch_src1_ready = r1; dispatch_src1_tag = t1; dispatch_src1 = d1;
    dispatch_src2_ready = r2; dispatch_src2_tag = t2; dispatch_src2 = d2;
    dispatch_imm = $urandom; dispatch_pc = $urandom;
    dispatch_funct3 = 3'($urandom); dispatch_ctrl = 9'($urandom);
    dispatch_br_dir_pred = 1'($urandom);
  endtask

  task automatic bc(input logic v, input logic [4:0] id, input logic [31:0] d);
    bcast_valid = v; bcast_rob_id = id; bcast_data = d;
  endtask

  task automatic idle(input int n);
    dispatch_valid = 0; bc(0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1; flush = 0; dispatch_valid = 0;
    dispatch_src1_ready = 0; dispatch_src2_ready = 0;
    dispatch_src1_tag = 0; dispatch_src2_tag = 0; dispatch_src1 = 0; dispatch_src2 = 0;
    dispatch_imm = 0; dispatch_pc = 0; dispatch_funct3 = 0; dispatch_ctrl = 0;
    dispatch_rob_id = 0; dispatch_br_dir_pred = 0;
    bc(0, 0, 0);
    exp_b = zero_instr(); exp_iv = 0;
    #12;
    check_outputs();
    rst = 0;
    @(posedge clk); #1;

    // ready dispatch: visible two cycles after the dispatch cycle
    set_disp(3, 1, 0, 5, 1, 0, 7); cycle();
    idle(1);
    chk("t1_rob", issue_rob_id, 3); chk("t1_src1", issue_src1, 5); chk("t1_src2", issue_src2, 7);
    idle(1);

    // wakeup; a non-matching broadcast must not capture
    set_disp(4, 0, 2, 0, 1, 0, 9); cycle();
    dispatch_valid = 0; bc(1, 9, 32'hdead); cycle();
    idle(1);
    bc(1, 2, 32'h1234); cycle();
    idle(1);
    chk("t2_src1", issue_src1, 32'h1234);
    idle(1);

    // same-cycle dispatch + broadcast
    set_disp(5, 1, 0, 1, 0, 6, 0); bc(1, 6, 32'hff); cycle();
    idle(1);
    chk("t3_src2", issue_src2, 32'hff);
    idle(1);

    // oldest-first: B, A, C
    set_disp(10, 0, 1, 0, 1, 0, 2); cycle();
    set_disp(11, 1, 0, 3, 1, 0, 4); cycle();
    set_disp(12, 1, 0, 5, 1, 0, 6); bc(1, 1, 32'h77); cycle();
    chk("t4_first", issue_rob_id, 11);
    idle(1); chk("t4_second", issue_rob_id, 10);
    idle(1); chk("t4_third", issue_rob_id, 12);
    idle(1);

    // full queue, wake entry 0, then a ninth dispatch
    for (int i = 0; i < N; i++) begin
      set_disp(5'(13 + i), 0, (i == 0) ? 5'd22 : 5'd21, 0, 1, 0, 32'(i)); cycle();
    end
    chk("t5_full", dispatch_ready, 0);
    dispatch_valid = 0; bc(1, 22, 32'h5555); cycle();
    idle(1);
    chk("t5_reopen", dispatch_ready, 1);
    set_disp(21, 1, 0, 8, 1, 0, 9); cycle();
    dispatch_valid = 0; bc(1, 21, 32'h4242); cycle();
    idle(12);

    // flush with 5 entries and an issue in flight
    for (int i = 0; i < 4; i++) begin set_disp(5'(22 + i), 0, 20, 0, 1, 0, 0); cycle(); end
    set_disp(26, 1, 0, 1, 1, 0, 2); cycle();
    set_disp(27, 0, 20, 0, 1, 0, 0); cycle();
    chk("t6_issue_before_flush", issue_valid, 1);
    set_disp(28, 1, 0, 3, 1, 0, 4); bc(1, 20, 32'h9); flush = 1; cycle();
    flush = 0;
    chk("t6_flush_iv", issue_valid, 0);
    dispatch_valid = 0;
    for (int i = 0; i < 3; i++) begin bc(1, 20, 32'h9); cycle(); end

    // asynchronous reset between edges
    set_disp(29, 1, 0, 6, 1, 0, 7); cycle();
    idle(1);
    chk("t6_iv_before_rst", issue_valid, 1);
    #3 rst = 1;
    #1 chk("t6_async_iv", issue_valid, 0);
    chk("t6_async_rob", issue_rob_id, 0);
    chk("t6_async_rdy", dispatch_ready, 1);
    mq.delete(); exp_b = zero_instr(); exp_iv = 0;
    #2 rst = 0;

    // randomized traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      if (mq.size() < N && $urandom_range(0, 2) != 0)
        set_disp(5'($urandom), 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 15)), $urandom);
      else
        dispatch_valid = 0;
      bc(1'($urandom), 5'($urandom_range(0, 15)), $urandom);
      flush = ($urandom_range(0, 99) == 0);
      cycle();
    end
    flush = 0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
